// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device transmitter for a PS/2 port. A one-cycle tx_start sends one
// command byte: the host inhibits the bus by holding CLK low, issues a request
// to send (DAT low, then CLK released), shifts out data/parity/stop on the
// device-generated falling CLK edges, checks the device ACK and waits for the
// bus to return idle.
//
// Parameters
//   INHIBIT_CYCLES  CLK hold-low time before the request, in clock cycles
//   TIMEOUT_CYCLES  watchdog limit counted from entry into DATA
//
// Ports
//   clock                 single rising-edge clock
//   rst_n                 asynchronous active-low reset
//   tx_data[7:0]          byte to send
//   tx_start              one-cycle send request, honoured only when idle
//   busy                  high while a transfer is in progress
//   done                  one-cycle pulse on a successful (acknowledged) transfer
//   error                 one-cycle pulse on an aborted transfer
//   ps2_clk_i/ps2_dat_i   raw pad levels
//   ps2_clk_oe/ps2_dat_oe open-drain pull-down enables (1 = drive low)
//
// Build option
//   PS2_TX_TIMEOUT_EN     when defined, a transfer that has not finished
//                         TIMEOUT_CYCLES after entering DATA aborts with error.
//                         Without it a stalled device keeps busy high until
//                         reset.
// -----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // One counter serves the inhibit time, the request time and the watchdog,
  // so it is sized for the largest of them.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 16) + 1;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(15);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQ     = 3'd2,
    S_DATA    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_idx;
  logic [10:0]      r_frame;
  logic             r_clk_oe;
  logic             r_dat_oe;
  logic             r_done;
  logic             r_error;

  logic             r_clk_meta;
  logic             r_clk_sync;
  logic             r_clk_prev;
  logic             r_dat_meta;
  logic             r_dat_sync;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [3:0]       w_idx_nx;
  logic [10:0]      w_frame_nx;
  logic             w_clk_oe_nx;
  logic             w_dat_oe_nx;
  logic             w_done_nx;
  logic             w_error_nx;
  logic             w_fall;
  logic             w_wd_hit;
  logic [CNT_W-1:0] w_wd_step;

  assign w_fall = r_clk_prev & ~r_clk_sync;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic w_in_xfer;
  // The counter is cleared on entry into DATA and keeps running through ACK
  // and RELEASE, so the limit is measured from DATA entry.
  assign w_in_xfer = (r_state == S_DATA) || (r_state == S_ACK) || (r_state == S_RELEASE);
  assign w_wd_hit  = w_in_xfer && (r_cnt == WD_LAST);
  assign w_wd_step = {{(CNT_W-1){1'b0}}, w_in_xfer};
`else
  assign w_wd_hit  = 1'b0;
  assign w_wd_step = '0;
`endif

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign error      = r_error;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

  // Two-flop synchronizers on the pads plus a delayed CLK copy for edge detect.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk_i;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_dat_i;
      r_dat_sync <= r_dat_meta;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= 4'd0;
      r_frame  <= 11'd0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_idx    <= w_idx_nx;
      r_frame  <= w_frame_nx;
      r_clk_oe <= w_clk_oe_nx;
      r_dat_oe <= w_dat_oe_nx;
      r_done   <= w_done_nx;
      r_error  <= w_error_nx;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // they change together with the state register.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_idx_nx    = r_idx;
    w_frame_nx  = r_frame;
    w_clk_oe_nx = r_clk_oe;
    w_dat_oe_nx = r_dat_oe;
    w_done_nx   = 1'b0;
    w_error_nx  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_oe_nx = 1'b0;
        w_dat_oe_nx = 1'b0;
        w_idx_nx    = 4'd0;
        w_cnt_nx    = '0;
        // A start coinciding with the done/error pulse of the previous
        // transfer is dropped.
        if (tx_start && !r_done && !r_error) begin
          w_frame_nx  = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
          w_clk_oe_nx = 1'b1;
          w_state_nx  = S_INHIBIT;
        end else begin
          w_state_nx  = S_IDLE;
        end
      end

      S_INHIBIT: begin
        w_clk_oe_nx = 1'b1;
        if (r_cnt == INHIBIT_LAST) begin
          w_cnt_nx    = '0;
          w_dat_oe_nx = ~r_frame[0];
          w_state_nx  = S_REQ;
        end else begin
          w_cnt_nx    = r_cnt + 1'b1;
        end
      end

      S_REQ: begin
        if (r_cnt == REQ_LAST) begin
          w_clk_oe_nx = 1'b0;
          w_cnt_nx    = '0;
          w_idx_nx    = 4'd0;
          w_state_nx  = S_DATA;
        end else begin
          w_cnt_nx    = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        w_clk_oe_nx = 1'b0;
        // Falling edge k (1..10) puts frame bit k on DAT; edge 10 is the stop
        // bit, which releases the line.
        if (w_fall) begin
          w_dat_oe_nx = ~r_frame[r_idx + 4'd1];
          if (r_idx == 4'd9) begin
            w_idx_nx   = 4'd0;
            w_state_nx = S_ACK;
          end else begin
            w_idx_nx   = r_idx + 4'd1;
          end
        end else begin
          w_state_nx = S_DATA;
        end
      end

      S_ACK: begin
        if (w_fall) begin
          if (!r_dat_sync) begin
            w_state_nx  = S_RELEASE;
          end else begin
            w_error_nx  = 1'b1;
            w_clk_oe_nx = 1'b0;
            w_dat_oe_nx = 1'b0;
            w_state_nx  = S_IDLE;
          end
        end else begin
          w_state_nx = S_ACK;
        end
      end

      S_RELEASE: begin
        if (r_clk_sync && r_dat_sync) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_RELEASE;
        end
      end

      default: begin
        w_clk_oe_nx = 1'b0;
        w_dat_oe_nx = 1'b0;
        w_state_nx  = S_IDLE;
      end
    endcase

    // Watchdog abort overrides whatever the state logic chose this cycle.
    if (w_wd_hit) begin
      w_state_nx  = S_IDLE;
      w_clk_oe_nx = 1'b0;
      w_dat_oe_nx = 1'b0;
      w_done_nx   = 1'b0;
      w_error_nx  = 1'b1;
      w_cnt_nx    = '0;
      w_idx_nx    = 4'd0;
    end else begin
      w_cnt_nx    = w_cnt_nx + w_wd_step;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// Testbench for ps2_host_tx: directed transfers against an open-drain PS/2
// device model. Expected outcomes and frames are queued when a send is issued;
// a monitor pops and compares on every done/error pulse.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int HALF       = 100;   // device half clock period, in cycles
  localparam int TB_TIMEOUT = 3000;  // watchdog limit used when the option is built in

  logic       clock = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy, done, error;
  logic       clk_oe, dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_i, ps2_dat_i;

  // Wired-AND open-drain bus.
  assign ps2_clk_i = dev_clk & ~clk_oe;
  assign ps2_dat_i = dev_dat & ~dat_oe;

  always #10 clock = ~clock;

  ps2_host_tx #(.INHIBIT_CYCLES(5000), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_dat_i  (ps2_dat_i),
    .ps2_clk_oe (clk_oe),
    .ps2_dat_oe (dat_oe)
  );

  typedef struct packed {
    logic        is_err;
    logic        chk_frame;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [10:0] dev_frame = 11'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    exp_t e;
    if (rst_n && (done || error)) begin
      check("done_error_exclusive", {31'd0, done & error}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, done, error}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("outcome_is_error", {31'd0, error}, {31'd0, e.is_err});
        if (e.chk_frame) check("sampled_frame", {21'd0, dev_frame}, {21'd0, e.frame});
        if (error) check("oe_on_error", {30'd0, clk_oe, dat_oe}, 32'd0);
        check("busy_at_pulse", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  // Device: waits for the request, clocks nclk bits (sampling DAT on rising
  // CLK) and, after the full 10, gives the 11th edge with or without ACK.
  task automatic dev_run(input logic ack, input int nclk);
    logic [10:0] f;
    int w;
    w = 0;
    f = 11'd0;
    while (!(dat_oe && !clk_oe) && w < 30000) begin
      @(posedge clock);
      w++;
    end
    if (w >= 30000) begin
      check("request_timeout", 32'd1, 32'd0);
      return;
    end
    f[0] = ps2_dat_i;
    repeat (HALF) @(posedge clock);
    for (int i = 1; i <= nclk; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(posedge clock);
      dev_clk = 1'b1;
      f[i] = ps2_dat_i;
      repeat (HALF) @(posedge clock);
    end
    dev_frame = f;
    if (nclk >= 10) begin
      if (ack) dev_dat = 1'b0;
      repeat (HALF / 2) @(posedge clock);
      dev_clk = 1'b0;
      repeat (HALF) @(posedge clock);
      dev_clk = 1'b1;
      repeat (HALF / 2) @(posedge clock);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy && w < 2000) begin
      @(negedge clock);
      w++;
    end
    if (w >= 2000) check(name, {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #3 rst_n = 1'b0;
    #1;
    check("rst_clk_oe", {31'd0, clk_oe}, 32'd0);
    check("rst_dat_oe", {31'd0, dat_oe}, 32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_pulses", {30'd0, done, error}, 32'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  initial begin
    int c_inh;
    int c_req;
    rst_n    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (5) @(negedge clock);
    check("reset_busy",   {31'd0, busy},   32'd0);
    check("reset_clk_oe", {31'd0, clk_oe}, 32'd0);
    check("reset_dat_oe", {31'd0, dat_oe}, 32'd0);
    check("reset_done",   {31'd0, done},   32'd0);
    check("reset_error",  {31'd0, error},  32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clock);

    // 0xFF, acked: frame start 0, data all ones, parity 1, stop 1.
    exp_q.push_back({1'b0, 1'b1, 11'h7FE});
    fork
      send(8'hFF);
      dev_run(1'b1, 10);
    join
    wait_idle("idle_after_ff");

    // 0xED, acked: six ones so parity 1; measure inhibit and request times.
    exp_q.push_back({1'b0, 1'b1, 11'h7DA});
    c_inh = 0;
    c_req = 0;
    fork
      begin
        send(8'hED);
        while (!dat_oe && c_inh < 20000) begin
          if (clk_oe) c_inh++;
          @(negedge clock);
        end
        while (clk_oe && c_req < 100) begin
          if (dat_oe) c_req++;
          @(negedge clock);
        end
      end
      dev_run(1'b1, 10);
    join
    check("inhibit_cycles", c_inh, 32'd5000);
    check("request_cycles", c_req, 32'd16);
    wait_idle("idle_after_ed");

    // 0x07, no ack: three ones so parity 0; error expected.
    exp_q.push_back({1'b1, 1'b1, 11'h40E});
    fork
      send(8'h07);
      dev_run(1'b0, 10);
    join
    wait_idle("idle_after_nack");

    // 0xA5 with a second start (0x00) mid-frame: first byte must go out.
    exp_q.push_back({1'b0, 1'b1, 11'h74A});
    fork
      begin
        send(8'hA5);
        repeat (5600) @(negedge clock);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
      end
      dev_run(1'b1, 10);
    join
    wait_idle("idle_after_a5");

    // Device stops clocking after 4 bits.
`ifdef PS2_TX_TIMEOUT_EN
    exp_q.push_back({1'b1, 1'b0, 11'h000});
`endif
    fork
      send(8'h55);
      dev_run(1'b1, 4);
    join
    repeat (TB_TIMEOUT + 200) @(negedge clock);
`ifdef PS2_TX_TIMEOUT_EN
    check("stall_busy_after_timeout", {31'd0, busy}, 32'd0);
`else
    check("stall_busy_held", {31'd0, busy}, 32'd1);
`endif
    pulse_reset();

    // Reset at bit 5 releases the lines immediately.
    fork
      send(8'h3C);
      dev_run(1'b1, 5);
    join
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    pulse_reset();

    // Fresh transfer after reset.
    exp_q.push_back({1'b0, 1'b1, 11'h702});
    fork
      send(8'h81);
      dev_run(1'b1, 10);
    join
    wait_idle("idle_after_81");

    repeat (50) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
